// File: rtl/apb_pkg.sv
// Shared APB completer types: FSM state encoding, response codes, wait-state bound.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } apb_slv_state_t;

  localparam logic APB_RESP_OK  = 1'b0;
  localparam logic APB_RESP_ERR = 1'b1;

  // Largest wait-state count a completer may insert; sizes the wait timer.
  localparam int APB_MAX_WAIT = 15;

endpackage

// File: rtl/apb_wait_timer.sv
// Loadable 4-bit down-counter; done is high while the count is zero.
// Latency: load/clear take effect on the next clock edge.
// Backpressure: none; dec at zero holds at zero instead of wrapping.
module apb_wait_timer
  import apb_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  load,
  input  logic [$clog2(APB_MAX_WAIT + 1)-1:0]   load_val,
  input  logic                                  dec,
  input  logic                                  clr,
  output logic                                  done
);

  localparam int CNT_W = $clog2(APB_MAX_WAIT + 1);

  logic [CNT_W-1:0] cnt;

  // Clear wins over load so an aborted transfer always leaves the timer at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/apb_reg_slave.sv
// APB completer in front of a bank of NUM_REGS word registers with RO masking and error decode.
// Latency: PREADY_o rises 1+WAIT_CYCLES cycles after the setup cycle; all APB outputs registered.
// Backpressure: PREADY_o held low for WAIT_CYCLES access cycles; dropping PSEL_i aborts without commit.
module apb_reg_slave
  import apb_pkg::*;
#(
  parameter int                  APB_DATA_WIDTH = 32,
  parameter int                  APB_ADDR_WIDTH = 32,
  parameter int                  NUM_REGS       = 8,
  parameter int                  WAIT_CYCLES    = 1,
  parameter logic [NUM_REGS-1:0] RO_MASK        = '0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [APB_ADDR_WIDTH-1:0]          PADDR_i,
  input  logic [APB_DATA_WIDTH-1:0]          PWDATA_i,
  input  logic                               PWRITE_i,
  input  logic                               PSEL_i,
  input  logic                               PENABLE_i,
  output logic [APB_DATA_WIDTH-1:0]          PRDATA_o,
  output logic                               PREADY_o,
  output logic                               PSLVERR_o,
  output logic [NUM_REGS*APB_DATA_WIDTH-1:0] regs_o,
  input  logic [NUM_REGS*APB_DATA_WIDTH-1:0] ro_data_i,
  output logic [NUM_REGS-1:0]                wr_pulse_o
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int CNT_W = $clog2(APB_MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  apb_slv_state_t            state;
  logic [IDX_W-1:0]          lat_idx;
  logic                      lat_write;
  logic [APB_DATA_WIDTH-1:0] lat_wdata;
  logic                      lat_err;
  logic [APB_DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                      setup;
  logic [IDX_W-1:0]          cur_idx;
  logic                      cur_err;
  logic [IDX_W-1:0]          rd_idx;
  logic                      rd_write;
  logic                      rd_err;
  logic [APB_DATA_WIDTH-1:0] rd_dat;
  logic                      commit;
  logic                      tmr_load;
  logic                      tmr_dec;
  logic                      tmr_clr;
  logic                      tmr_done;

  assign setup   = PSEL_i && !PENABLE_i;
  assign cur_idx = PADDR_i[IDX_W+1:2];
  // Misaligned, beyond the bank, or a write aimed at a read-only register.
  assign cur_err = (PADDR_i[1:0] != 2'b00) ||
                   ((PADDR_i >> (IDX_W + 2)) != '0) ||
                   (PWRITE_i && RO_MASK[cur_idx]);

  // With zero wait states RESP is entered straight from the setup sample, so use the live
  // bus; otherwise use the values latched at setup.
  always_comb begin
    rd_idx   = (state == IDLE) ? cur_idx  : lat_idx;
    rd_write = (state == IDLE) ? PWRITE_i : lat_write;
    rd_err   = (state == IDLE) ? cur_err  : lat_err;
    rd_dat   = RO_MASK[rd_idx] ? ro_data_i[int'(rd_idx)*APB_DATA_WIDTH +: APB_DATA_WIDTH]
                               : regs[rd_idx];
    if (rd_err || rd_write) begin
      rd_dat = '0;
    end
  end

  assign commit   = (state == RESP) && PSEL_i && PENABLE_i && lat_write && !lat_err;
  assign tmr_load = (state == IDLE) && setup && (WAIT_CYCLES != 0);
  assign tmr_dec  = (state == WAIT) && PSEL_i;
  assign tmr_clr  = (state == WAIT) && !PSEL_i;

  apb_wait_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (WAIT_LOAD),
    .dec      (tmr_dec),
    .clr      (tmr_clr),
    .done     (tmr_done)
  );

  // Transfer sequencing with registered APB response outputs and the write strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lat_idx    <= '0;
      lat_write  <= 1'b0;
      lat_wdata  <= '0;
      lat_err    <= APB_RESP_OK;
      PREADY_o   <= 1'b0;
      PSLVERR_o  <= APB_RESP_OK;
      PRDATA_o   <= '0;
      wr_pulse_o <= '0;
    end else begin
      wr_pulse_o <= '0;
      if (commit) begin
        wr_pulse_o[lat_idx] <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (setup) begin
            lat_idx   <= cur_idx;
            lat_write <= PWRITE_i;
            lat_wdata <= PWDATA_i;
            lat_err   <= cur_err;
            if (WAIT_CYCLES == 0) begin
              state     <= RESP;
              PREADY_o  <= 1'b1;
              PSLVERR_o <= rd_err;
              PRDATA_o  <= rd_dat;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!PSEL_i) begin
            state <= IDLE;
          end else if (tmr_done) begin
            state     <= RESP;
            PREADY_o  <= 1'b1;
            PSLVERR_o <= rd_err;
            PRDATA_o  <= rd_dat;
          end
        end
        RESP: begin
          state     <= IDLE;
          PREADY_o  <= 1'b0;
          PSLVERR_o <= APB_RESP_OK;
          PRDATA_o  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Register bank: only committed, error-free writes land; RO entries are never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (commit && !RO_MASK[lat_idx]) begin
      regs[lat_idx] <= lat_wdata;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs_out
    assign regs_o[i*APB_DATA_WIDTH +: APB_DATA_WIDTH] = RO_MASK[i] ? '0 : regs[i];
  end

endmodule
